btn_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 17 +
 rtl/sync2.sv | 22 ++
 rtl/btn_conditioner.sv | 155 +++++++++++++++
 tb/tb_btn_conditioner.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button conditioner.
// BTN_REPEAT_EN (see btn_conditioner) consumes the repeat defaults below.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_QUAL = 2'd1,
        HELD       = 2'd2,
        REL_QUAL   = 2'd3
    } btn_state_e;

    localparam int STABLE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF         = 8;
    localparam int REPEAT_DELAY_DEF  = 50;
    localparam int REPEAT_PERIOD_DEF = 10;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with synchronous active-low reset.
// Shared by every asynchronous input in the slow clock domain.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Debounces one raw button into a level and a one-cycle press pulse.
// Define BTN_REPEAT_EN to add auto-repeat pulses while the button is held.
//
// state      | meaning
// IDLE       | debounced level 0, waiting for a 1
// PRESS_QUAL | counting stable 1 samples
// HELD       | debounced level 1, waiting for a 0
// REL_QUAL   | counting stable 0 samples
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic noisy_in,
    output logic clean_out,
    output logic level_out,
    output logic busy
);

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || STABLE_CYCLES >= (1 << CNT_W) ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("btn_conditioner: illegal parameter value");
    end

    btn_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             s2;
    logic             press;
    logic             rpt_fire;
    logic             pulse_nxt, level_nxt, busy_nxt;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (noisy_in),
        .q   (s2)
    );

    // Saturating increment so the qualify counter can never wrap.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            clean_out <= 1'b0;
            level_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            clean_out <= pulse_nxt;
            level_out <= level_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press     = 1'b0;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_nxt = PRESS_QUAL;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            PRESS_QUAL: begin
                if (!s2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_CNT) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    press     = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            HELD: begin
                if (!s2) begin
                    state_nxt = REL_QUAL;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            REL_QUAL: begin
                if (s2) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_CNT) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state and registered above.
    always_comb begin
        pulse_nxt = press | rpt_fire;
        level_nxt = (state_nxt == HELD) || (state_nxt == REL_QUAL);
        busy_nxt  = (state_nxt == PRESS_QUAL) || (state_nxt == REL_QUAL);
    end

`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nxt;

    // Non-press entry into HELD/REL_QUAL only comes from HELD/REL_QUAL,
    // so a release bounce keeps the repeat timer running.
    always_comb begin
        rpt_cnt_nxt = rpt_cnt;
        rpt_fire    = 1'b0;
        if (press) begin
            rpt_cnt_nxt = RPT_DELAY_LD;
        end else if ((state_nxt == HELD) || (state_nxt == REL_QUAL)) begin
            if (rpt_cnt == '0) begin
                rpt_fire    = 1'b1;
                rpt_cnt_nxt = RPT_PERIOD_LD;
            end else begin
                rpt_cnt_nxt = rpt_cnt - CNT_W'(1);
            end
        end else begin
            rpt_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt_nxt;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a run-length reference model.
module tb_btn_conditioner;

    localparam int STABLE = 4;
    localparam int RD     = 50;
    localparam int RP     = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic noisy_in = 1'b0;
    logic clean_out, level_out, busy;

    always #5 clk = ~clk;

    btn_conditioner #(
        .STABLE_CYCLES (STABLE),
        .CNT_W         (8),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .noisy_in  (noisy_in),
        .clean_out (clean_out),
        .level_out (level_out),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference model: the input reaches the qualifier two edges late; the
    // level flips once the input has disagreed with it for STABLE+1 edges.
    bit d1, d2;
    bit m_level, m_pulse, m_valid;
    int m_run;
`ifdef BTN_REPEAT_EN
    int m_k;
`endif

    always @(posedge clk) begin
        bit x;
        if (!rst) begin
            d1 = 0; d2 = 0; m_level = 0; m_pulse = 0; m_run = 0;
`ifdef BTN_REPEAT_EN
            m_k = 0;
`endif
        end else begin
            x  = d2;
            d2 = d1;
            d1 = noisy_in;
            m_pulse = 0;
            if (x != m_level) m_run++;
            else m_run = 0;
            if (m_run > STABLE) begin
                m_level = x;
                m_run   = 0;
                if (x) begin
                    m_pulse = 1;
`ifdef BTN_REPEAT_EN
                    m_k = 0;
`endif
                end
            end else if (m_level) begin
`ifdef BTN_REPEAT_EN
                m_k++;
                if (m_k >= RD && (m_k - RD) % RP == 0) m_pulse = 1;
`endif
            end
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_clean", clean_out, m_pulse);
            check("model_level", level_out, m_level);
            check("model_busy", busy, m_run != 0);
            if (clean_out === 1'b1) pulses++;
        end
    end

    initial begin
        int p;
        bit found;
        logic [4:0] bounce;

        // Reset
        rst = 0; noisy_in = 0;
        tick(); tick();
        check("rst_clean", clean_out, 1'b0);
        check("rst_level", level_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1;
        tick(); tick();

        // Clean press: pulse on the 7th edge after assertion
        p = pulses;
        noisy_in = 1;
        tick(); tick();
        check("press_busy_early", busy, 1'b0);
        repeat (4) tick();
        check("press_busy", busy, 1'b1);
        check("press_no_pulse_yet", clean_out, 1'b0);
        tick();
        check("press_pulse", clean_out, 1'b1);
        check("press_level", level_out, 1'b1);
        check("press_busy_done", busy, 1'b0);
        tick();
        check("press_pulse_single", clean_out, 1'b0);
        repeat (12) tick();
        check_int("press_count", pulses, p + 1);
        noisy_in = 0;
        repeat (10) tick();
        check("press_released", level_out, 1'b0);

        // Bounce 1,0,1,0,1 then held
        p = pulses;
        bounce = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            noisy_in = bounce[i];
            tick();
        end
        check_int("bounce_no_pulse", pulses, p);
        check("bounce_level_low", level_out, 1'b0);
        noisy_in = 1;
        repeat (12) tick();
        check_int("bounce_one_pulse", pulses, p + 1);
        check("bounce_level_high", level_out, 1'b1);

        // Release bounce 0,1,0 from HELD
        p = pulses;
        noisy_in = 0; tick();
        noisy_in = 1; tick();
        noisy_in = 0;
        repeat (6) tick();
        check("relb_level_still_high", level_out, 1'b1);
        tick();
        check("relb_level_fell", level_out, 1'b0);
        repeat (3) tick();
        check_int("relb_no_pulse", pulses, p);

        // Short glitch of 3 cycles
        p = pulses;
        noisy_in = 1;
        repeat (3) tick();
        noisy_in = 0;
        repeat (8) tick();
        check_int("glitch_no_pulse", pulses, p);
        check("glitch_level", level_out, 1'b0);
        check("glitch_idle", busy, 1'b0);

        // Reset while held, button still pressed afterwards
        noisy_in = 1;
        repeat (10) tick();
        check("held_level", level_out, 1'b1);
        p = pulses;
        rst = 0;
        tick();
        check("rst_held_clean", clean_out, 1'b0);
        check("rst_held_level", level_out, 1'b0);
        check("rst_held_busy", busy, 1'b0);
        rst = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (clean_out === 1'b1) found = 1;
        end
        check("requal_pulse_seen", found, 1'b1);
        repeat (5) tick();
        check_int("requal_one_pulse", pulses, p + 1);
        noisy_in = 0;
        repeat (10) tick();

        // Reset at the very edge a qualification would complete
        p = pulses;
        noisy_in = 1;
        repeat (6) tick();
        rst = 0;
        tick();
        check("race_clean", clean_out, 1'b0);
        check("race_level", level_out, 1'b0);
        noisy_in = 0;
        rst = 1;
        repeat (5) tick();
        check_int("race_no_pulse", pulses, p);

`ifdef BTN_REPEAT_EN
        begin
            int rpt_offsets [6];
            bit exp_p;
            rpt_offsets = '{50, 60, 70, 80, 90, 100};
            noisy_in = 1;
            found = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                tick();
                if (clean_out === 1'b1) found = 1;
            end
            check("rpt_press_seen", found, 1'b1);
            p = pulses;
            for (int k = 1; k <= 120; k++) begin
                tick();
                exp_p = 0;
                foreach (rpt_offsets[j]) if (rpt_offsets[j] == k) exp_p = 1;
                check("rpt_offset", clean_out, exp_p);
                if (k == 100) noisy_in = 0;
            end
            check_int("rpt_count", pulses, p + 6);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
